refresh_sched: RTL and testbench

REFRESH_SCHED -- requirements
Module: refresh_sched

---
 rtl/refresh_pkg.sv | 19 +
 rtl/ref_tick.sv | 33 +++
 rtl/refresh_sched.sv | 111 +++++++++++
 tb/tb_refresh_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared refresh-scheduler constants and types, also used by the RAM controller bench.
package refresh_pkg;

    localparam int unsigned REF_INTERVAL_DEF = 390;
    localparam int unsigned URG_AGE_DEF      = 64;
    localparam int unsigned MAX_PEND_DEF     = 4;
    localparam int unsigned PEND_W           = 3;
    // Idle FSB cycles this close to the next tick may pull a refresh forward.
    localparam int unsigned OPP_WINDOW       = 32;

    typedef logic [PEND_W-1:0] pend_t;

    typedef enum logic [1:0] {
        PendHold,
        PendInc,
        PendDec
    } pend_op_e;

endpackage

// File: rtl/ref_tick.sv
// Free-running refresh interval counter; tick_o marks the wrap cycle.
module ref_tick #(
    parameter int unsigned Interval = 390,
    parameter int unsigned CntW     = $clog2(Interval)
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            restart_i,
    output logic            tick_o,
    output logic [CntW-1:0] count_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o  = (cnt_q == CntW'(Interval - 1));
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o || restart_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/refresh_sched.sv
// DRAM refresh scheduler: counts owed refreshes, ages the oldest one and
// raises request/urgent flags for the RAM controller.
module refresh_sched
    import refresh_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int unsigned URG_AGE      = URG_AGE_DEF,
    parameter int unsigned MAX_PEND     = MAX_PEND_DEF
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              RefAck,
    input  logic              BACT,
    output logic              RefReq,
    output logic              RefUrg,
    output logic              RefOvf,
    output logic [PEND_W-1:0] PendCnt
);

    localparam int unsigned CntW = $clog2(REF_INTERVAL);
    localparam int unsigned AgeW = $clog2(URG_AGE + 1);

    if (REF_INTERVAL <= OPP_WINDOW || MAX_PEND > 7 || MAX_PEND == 0) begin : gen_param_err
        $error("refresh_sched: need REF_INTERVAL > 32 and 1 <= MAX_PEND <= 7");
    end

    logic            tick;
    logic            restart;
    logic [CntW-1:0] tick_cnt;
    pend_op_e        op;
    pend_t           pend_q, pend_d;
    logic [AgeW-1:0] age_q, age_d;
    logic            req_q, req_d;
    logic            urg_q, urg_d;
    logic            ovf_q, ovf_d;

    // An ack with nothing owed was an opportunistic refresh: start a fresh interval.
    assign restart = RefAck && !tick && (pend_q == '0);

    ref_tick #(
        .Interval(REF_INTERVAL),
        .CntW    (CntW)
    ) u_ref_tick (
        .CLK      (CLK),
        .RES      (RES),
        .restart_i(restart),
        .tick_o   (tick),
        .count_o  (tick_cnt)
    );

    always_comb begin
        op = PendHold;
        if (tick && !RefAck) begin
            op = PendInc;
        end else if (!tick && RefAck) begin
            op = PendDec;
        end

        pend_d = pend_q;
        ovf_d  = ovf_q;
        unique case (op)
            PendInc: begin
                if (pend_q == pend_t'(MAX_PEND)) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
            PendDec: begin
                if (pend_q != '0) begin
                    pend_d = pend_q - 1'b1;
                end
            end
            default: ;
        endcase

        age_d = age_q;
        if (RefAck || (pend_q == '0)) begin
            age_d = '0;
        end else if (age_q < AgeW'(URG_AGE)) begin
            age_d = age_q + 1'b1;
        end

        // Outputs are registered from next state so they follow the causing edge directly.
        req_d = (pend_d != '0)
              || (!BACT && !RefAck && (tick_cnt >= CntW'(REF_INTERVAL - OPP_WINDOW)));
        urg_d = (pend_d >= pend_t'(2)) || (age_d == AgeW'(URG_AGE));
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            pend_q <= '0;
            age_q  <= '0;
            req_q  <= 1'b0;
            urg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            age_q  <= age_d;
            req_q  <= req_d;
            urg_q  <= urg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign RefReq  = req_q;
    assign RefUrg  = urg_q;
    assign RefOvf  = ovf_q;
    assign PendCnt = pend_q;

endmodule

// File: tb/tb_refresh_sched.sv
// Bench for refresh_sched: stimulus table plus hand sequences, expectations queued and popped.
module tb_refresh_sched;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       RefAck = 1'b0;
    logic       BACT = 1'b1;
    logic       RefReq, RefUrg, RefOvf;
    logic [2:0] PendCnt;

    int n_checks = 0;
    int n_fail   = 0;

    refresh_sched dut (
        .CLK    (CLK),
        .RES    (RES),
        .RefAck (RefAck),
        .BACT   (BACT),
        .RefReq (RefReq),
        .RefUrg (RefUrg),
        .RefOvf (RefOvf),
        .PendCnt(PendCnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       res;
        logic       ack;
        logic       bact;
        int         n;
        logic       req;
        logic       urg;
        logic       ovf;
        logic [2:0] pend;
    } vec_t;

    typedef struct {
        string      name;
        logic       req;
        logic       urg;
        logic       ovf;
        logic [2:0] pend;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        n_checks--;
        e = sb.pop_front();
        check({e.name, ".RefReq"}, int'(RefReq), int'(e.req));
        check({e.name, ".RefUrg"}, int'(RefUrg), int'(e.urg));
        check({e.name, ".RefOvf"}, int'(RefOvf), int'(e.ovf));
        check({e.name, ".PendCnt"}, int'(PendCnt), int'(e.pend));
    endtask

    // Drive inputs for n edges, then compare against the queued expectation.
    task automatic run(input string name, input logic res, input logic ack, input logic bact,
                       input int n, input logic req, input logic urg, input logic ovf,
                       input logic [2:0] pend);
        exp_t e;
        e.name = name; e.req = req; e.urg = urg; e.ovf = ovf; e.pend = pend;
        sb.push_back(e);
        RES = res; RefAck = ack; BACT = bact;
        repeat (n) @(posedge CLK);
        #1;
        RES = 1'b0; RefAck = 1'b0;
        pop_compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // res ack bact n | req urg ovf pend
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1,   1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 389, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 3'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 63,  1'b1, 1'b0, 1'b0, 3'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b1, 1'b0, 3'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0, 3'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 324, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 3'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 390, 1'b1, 1'b1, 1'b0, 3'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 389, 1'b1, 1'b1, 1'b0, 3'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1,   1'b1, 1'b1, 1'b0, 3'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 390, 1'b1, 1'b1, 1'b0, 3'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 390, 1'b1, 1'b1, 1'b0, 3'd4};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 389, 1'b1, 1'b1, 1'b0, 3'd4};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b1, 1'b1, 3'd4};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1,   1'b1, 1'b1, 1'b1, 3'd3};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1,   1'b1, 1'b1, 1'b1, 3'd2};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1,   1'b1, 1'b0, 1'b1, 3'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b1, 3'd0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b1, 3'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0, 3'd0};

        for (int i = 0; i < 21; i++) begin
            run($sformatf("vec%0d", i), vecs[i].res, vecs[i].ack, vecs[i].bact, vecs[i].n,
                vecs[i].req, vecs[i].urg, vecs[i].ovf, vecs[i].pend);
        end

        // Opportunistic window opens at count 358 when the bus is idle.
        run("opp_pre",      1'b0, 1'b0, 1'b1, 357, 1'b0, 1'b0, 1'b0, 3'd0);
        run("opp_357",      1'b0, 1'b0, 1'b0, 1,   1'b0, 1'b0, 1'b0, 3'd0);
        run("opp_358",      1'b0, 1'b0, 1'b0, 1,   1'b1, 1'b0, 1'b0, 3'd0);
        run("opp_ack",      1'b0, 1'b1, 1'b0, 1,   1'b0, 1'b0, 1'b0, 3'd0);
        run("opp_restart",  1'b0, 1'b0, 1'b1, 389, 1'b0, 1'b0, 1'b0, 3'd0);
        run("opp_next_tick",1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 3'd1);

        // Reset mid-operation with three refreshes owed.
        run("res_pend2",    1'b0, 1'b0, 1'b1, 390, 1'b1, 1'b1, 1'b0, 3'd2);
        run("res_pend3",    1'b0, 1'b0, 1'b1, 390, 1'b1, 1'b1, 1'b0, 3'd3);
        run("res_mid",      1'b1, 1'b1, 1'b0, 1,   1'b0, 1'b0, 1'b0, 3'd0);
        BACT = 1'b1;
        k = 0;
        while (!RefReq && k < 1000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("first_req_after_res", k, 390);

        // Tick coincident with ack while nothing owed: count stays 0.
        run("zero_ack",     1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0, 3'd0);
        run("zero_wait",    1'b0, 1'b0, 1'b1, 388, 1'b0, 1'b0, 1'b0, 3'd0);
        run("zero_tickack", 1'b0, 1'b1, 1'b1, 1,   1'b0, 1'b0, 1'b0, 3'd0);
        run("zero_after",   1'b0, 1'b0, 1'b1, 389, 1'b0, 1'b0, 1'b0, 3'd0);
        run("zero_tick",    1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b0, 1'b0, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
